// File: rtl/temp_avg_pkg.sv
// Shared types and helpers for the multi-channel temperature averager:
// FSM state type, sizing helpers and sign-magnitude <-> two's complement conversion.
package temp_avg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Conversions work on a fixed 32-bit container; callers pass the real word width.
  localparam int MAX_W = 32;

  function automatic int acc_width(input int data_w, input int log2_win);
    return data_w + log2_win;
  endfunction

  function automatic int win_len(input int log2_win);
    return 1 << log2_win;
  endfunction

  // Negative zero (sign set, magnitude 0) naturally maps to 0.
  function automatic logic signed [MAX_W-1:0] sm2tc(input logic [MAX_W-1:0] sm, input int w);
    logic [MAX_W-1:0] mag;
    logic             neg;
    mag = sm & ((MAX_W'(1) << (w - 1)) - MAX_W'(1));
    neg = ((sm >> (w - 1)) & MAX_W'(1)) != '0;
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // A zero result always carries sign bit 0.
  function automatic logic [MAX_W-1:0] tc2sm(input logic signed [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    if (v < 0) r = (MAX_W'(1) << (w - 1)) | MAX_W'(-v);
    else       r = MAX_W'(v);
    return r;
  endfunction

endpackage

// File: rtl/temp_avg_if.sv
// Bus between the averager (master) and its sensor/report neighbours (slave).
// min_out/max_out exist only when TEMP_AVG_MINMAX_EN is defined.
interface temp_avg_if #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 9,
  parameter int LOG2_WIN = 6
);
  logic                     en;
  logic [N_CH*DATA_W-1:0]   temp_in;
  logic                     sample_tick;
  logic [LOG2_WIN-1:0]      sample_idx;
  logic [N_CH*DATA_W-1:0]   avg_out;
  logic                     avg_valid;

`ifdef TEMP_AVG_MINMAX_EN
  logic [N_CH*DATA_W-1:0]   min_out;
  logic [N_CH*DATA_W-1:0]   max_out;

  modport master (
    input  en, temp_in,
    output sample_tick, sample_idx, avg_out, avg_valid, min_out, max_out
  );
  modport slave (
    output en, temp_in,
    input  sample_tick, sample_idx, avg_out, avg_valid, min_out, max_out
  );
`else
  modport master (
    input  en, temp_in,
    output sample_tick, sample_idx, avg_out, avg_valid
  );
  modport slave (
    output en, temp_in,
    input  sample_tick, sample_idx, avg_out, avg_valid
  );
`endif

endinterface

// File: rtl/temp_avg_chan.sv
// One averaging channel: converts each strobed sample to two's complement, accumulates
// the window and publishes the floor average. Min/max tracking under TEMP_AVG_MINMAX_EN.
module temp_avg_chan
  import temp_avg_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int LOG2_WIN = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic              done,
  input  logic              clear,
  input  logic [DATA_W-1:0] temp,
  output logic [DATA_W-1:0] avg
`ifdef TEMP_AVG_MINMAX_EN
  ,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out
`endif
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_WIN);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] cur;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] mean;

  assign cur  = ACC_W'(sm2tc(MAX_W'(temp), DATA_W));
  assign sum  = acc + cur;
  assign mean = sum >>> LOG2_WIN;

  // done always coincides with the final sample of the window, so it publishes sum, not acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      avg <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (sample) begin
      if (done) begin
        acc <= '0;
        avg <= DATA_W'(tc2sm(MAX_W'(mean), DATA_W));
      end else begin
        acc <= sum;
      end
    end
  end

`ifdef TEMP_AVG_MINMAX_EN
  logic signed [ACC_W-1:0] lo, hi, lo_n, hi_n;
  logic                    first;

  assign lo_n = (first || cur < lo) ? cur : lo;
  assign hi_n = (first || cur > hi) ? cur : hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      lo      <= '0;
      hi      <= '0;
      first   <= 1'b1;
      min_out <= '0;
      max_out <= '0;
    end else if (clear) begin
      first <= 1'b1;
    end else if (sample) begin
      if (done) begin
        first   <= 1'b1;
        min_out <= DATA_W'(tc2sm(MAX_W'(lo_n), DATA_W));
        max_out <= DATA_W'(tc2sm(MAX_W'(hi_n), DATA_W));
      end else begin
        first <= 1'b0;
        lo    <= lo_n;
        hi    <= hi_n;
      end
    end
  end
`endif

endmodule

// File: rtl/temp_avg_multi.sv
// Multi-channel windowed temperature averager: FSM, sample prescaler and window index,
// with one temp_avg_chan per channel. Optional min/max outputs under TEMP_AVG_MINMAX_EN.
//
// state | meaning
// IDLE  | disabled; prescaler, index and accumulators held clear
// RUN   | prescaler counting, every channel sampled on each tick
// DONE  | one-cycle slot where the new averages are visible with avg_valid
module temp_avg_multi
  import temp_avg_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int DATA_W         = 9,
  parameter int CLK_PER_SAMPLE = 50000000,
  parameter int LOG2_WIN       = 6
) (
  input  logic       clk,
  input  logic       rst,
  temp_avg_if.master bus
);

  localparam int             WIN      = win_len(LOG2_WIN);
  localparam int             PW       = $clog2(CLK_PER_SAMPLE);
  localparam logic [PW-1:0]  PRE_LOAD = PW'(CLK_PER_SAMPLE - 1);

  state_t              state;
  logic [PW-1:0]       presc;
  logic [LOG2_WIN-1:0] idx;
  logic                valid_q;

  logic tick, last, sample_s, done_s, clear_s;

  // Down-counter: loaded with CLK_PER_SAMPLE-1 on entering RUN, ticks at terminal count.
  assign tick     = (presc == '0);
  assign last     = (idx == LOG2_WIN'(WIN - 1));
  assign sample_s = tick && (state == RUN) && bus.en;
  assign done_s   = sample_s && last;
  assign clear_s  = (state == RUN) && !bus.en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= PRE_LOAD;
      idx     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          presc <= PRE_LOAD;
          idx   <= '0;
          if (bus.en) state <= RUN;
        end
        RUN: begin
          if (!bus.en) begin
            state <= IDLE;
            presc <= PRE_LOAD;
            idx   <= '0;
          end else if (tick) begin
            presc <= PRE_LOAD;
            idx   <= idx + LOG2_WIN'(1);
            if (last) begin
              state   <= DONE;
              valid_q <= 1'b1;
            end
          end else begin
            presc <= presc - PW'(1);
          end
        end
        DONE: begin
          // No tick can land here, so the prescaler just keeps its cadence.
          if (!bus.en) begin
            state <= IDLE;
            presc <= PRE_LOAD;
            idx   <= '0;
          end else begin
            state <= RUN;
            presc <= presc - PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sample_tick = tick;
  assign bus.sample_idx  = idx;
  assign bus.avg_valid   = valid_q;

  logic [N_CH*DATA_W-1:0] avg_all;
  assign bus.avg_out = avg_all;

`ifdef TEMP_AVG_MINMAX_EN
  logic [N_CH*DATA_W-1:0] min_all, max_all;
  assign bus.min_out = min_all;
  assign bus.max_out = max_all;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    temp_avg_chan #(
      .DATA_W   (DATA_W),
      .LOG2_WIN (LOG2_WIN)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .sample  (sample_s),
      .done    (done_s),
      .clear   (clear_s),
      .temp    (bus.temp_in[c*DATA_W +: DATA_W]),
      .avg     (avg_all[c*DATA_W +: DATA_W])
`ifdef TEMP_AVG_MINMAX_EN
      ,
      .min_out (min_all[c*DATA_W +: DATA_W]),
      .max_out (max_all[c*DATA_W +: DATA_W])
`endif
    );
  end

endmodule

// File: tb/tb_temp_avg_multi.sv
// Bench for temp_avg_multi: window vector table, en-drop and reset sequences, then random
// stimulus, all checked cycle by cycle against a queue-based model of the averaging rules.
module tb_temp_avg_multi;

  localparam int N_CH = 2;
  localparam int DW   = 9;
  localparam int CPS  = 4;
  localparam int L    = 2;
  localparam int WIN  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  temp_avg_if #(.N_CH(N_CH), .DATA_W(DW), .LOG2_WIN(L)) bus ();

  temp_avg_multi #(
    .N_CH(N_CH), .DATA_W(DW), .CLK_PER_SAMPLE(CPS), .LOG2_WIN(L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: cycles since entering run, per-channel sample queues, published averages.
  bit          m_active = 0;
  bit          m_done   = 0;
  int          m_cyc    = 0;
  int          m_q[N_CH][$];
  logic [17:0] m_avg    = '0;

  typedef struct {
    logic [35:0] s0;
    logic [35:0] s1;
    logic [8:0]  e0;
    logic [8:0]  e1;
    logic [8:0]  mn0;
    logic [8:0]  mx0;
  } vec_t;
  vec_t vt[5];

  function automatic int sm2int(input logic [8:0] s);
    int m;
    m = int'(s[7:0]);
    return s[8] ? -m : m;
  endfunction

  function automatic logic [8:0] int2sm(input int v);
    if (v < 0) return {1'b1, 8'(-v)};
    return {1'b0, 8'(v)};
  endfunction

  function automatic int fdiv(input int s);
    if (s >= 0) return s / WIN;
    return -((-s + WIN - 1) / WIN);
  endfunction

  function automatic bit m_tick();
    return m_active && !m_done && ((m_cyc % CPS) == CPS - 1);
  endfunction

  function automatic void model_step(input logic r, input logic e, input logic [17:0] t);
    bit tk;
    tk = m_tick();
    if (r) begin
      m_active = 0; m_done = 0; m_cyc = 0; m_avg = '0;
      for (int c = 0; c < N_CH; c++) m_q[c].delete();
    end else if (!m_active) begin
      if (e) begin m_active = 1; m_cyc = 0; end
    end else if (m_done) begin
      m_done = 0;
      if (!e) m_active = 0;
      else    m_cyc++;
    end else if (!e) begin
      m_active = 0;
      for (int c = 0; c < N_CH; c++) m_q[c].delete();
    end else begin
      if (tk) begin
        for (int c = 0; c < N_CH; c++) m_q[c].push_back(sm2int(t[c*DW +: DW]));
        if (m_q[0].size() == WIN) begin
          for (int c = 0; c < N_CH; c++) begin
            int s;
            s = 0;
            foreach (m_q[c][k]) s += m_q[c][k];
            m_avg[c*DW +: DW] = int2sm(fdiv(s));
            m_q[c].delete();
          end
          m_done = 1;
        end
      end
      m_cyc++;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step(rst, bus.en, bus.temp_in);
    @(posedge clk);
    #1;
    chk("tick",  32'(bus.sample_tick), 32'(m_tick()));
    chk("idx",   32'(bus.sample_idx),  32'(m_q[0].size()));
    chk("valid", 32'(bus.avg_valid),   32'(m_done));
    chk("avg",   32'(bus.avg_out),     32'(m_avg));
  endtask

  task automatic run_window(input vec_t v);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      int n;
      n = m_q[0].size();
      bus.temp_in = {v.s1[n*DW +: DW], v.s0[n*DW +: DW]};
      step();
      seen = bus.avg_valid;
    end
    chk("win_done", 32'(seen), 32'd1);
    if (seen) begin
      chk("avg_ch0", 32'(bus.avg_out[8:0]),  32'(v.e0));
      chk("avg_ch1", 32'(bus.avg_out[17:9]), 32'(v.e1));
`ifdef TEMP_AVG_MINMAX_EN
      chk("min_ch0", 32'(bus.min_out[8:0]), 32'(v.mn0));
      chk("max_ch0", 32'(bus.max_out[8:0]), 32'(v.mx0));
`endif
    end
  endtask

  // Waits for n ticks, then one more cycle so the last ticked sample is taken.
  task automatic take_ticks(input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 40 && seen < n; k++) begin
      step();
      if (bus.sample_tick) seen++;
    end
    chk("ticks", 32'(seen), 32'(n));
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    bit vseen;
    vt[0] = '{{4{9'h019}}, {4{9'h119}}, 9'h019, 9'h119, 9'h019, 9'h019};
    vt[1] = '{{9'h103, 9'h103, 9'h00A, 9'h00A}, {9'h000, 9'h000, 9'h000, 9'h101},
              9'h003, 9'h101, 9'h103, 9'h00A};
    vt[2] = '{{4{9'h0FF}}, {4{9'h100}}, 9'h0FF, 9'h000, 9'h0FF, 9'h0FF};
    vt[3] = '{{9'h000, 9'h00C, 9'h003, 9'h107}, {4{9'h1FF}}, 9'h002, 9'h1FF, 9'h107, 9'h00C};
    vt[4] = '{{9'h102, 9'h101, 9'h101, 9'h101}, {9'h000, 9'h001, 9'h001, 9'h001},
              9'h102, 9'h000, 9'h102, 9'h101};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.temp_in = '0;
    step();
    step();
    chk("rst_tick",  32'(bus.sample_tick), 32'd0);
    chk("rst_idx",   32'(bus.sample_idx),  32'd0);
    chk("rst_valid", 32'(bus.avg_valid),   32'd0);
    chk("rst_avg",   32'(bus.avg_out),     32'd0);

    rst = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) run_window(vt[i]);

    // en dropped after two samples: window aborted, averages held, restart excludes them.
    bus.temp_in = {9'h050, 9'h050};
    take_ticks(2);
    bus.en = 1'b0;
    vseen = 0;
    repeat (3) begin
      step();
      vseen |= bus.avg_valid;
    end
    chk("drop_no_valid", 32'(vseen), 32'd0);
    chk("drop_idx",      32'(bus.sample_idx), 32'd0);
    chk("drop_hold",     32'(bus.avg_out), 32'h00102);
    bus.en = 1'b1;
    run_window(vt[0]);

    // Reset mid-window: everything clears; next average uses only post-reset samples.
    bus.temp_in = {9'h0FF, 9'h0FF};
    take_ticks(2);
    rst = 1'b1;
    step();
    chk("rst2_avg",   32'(bus.avg_out),     32'd0);
    chk("rst2_valid", 32'(bus.avg_valid),   32'd0);
    chk("rst2_idx",   32'(bus.sample_idx),  32'd0);
    chk("rst2_tick",  32'(bus.sample_tick), 32'd0);
    rst = 1'b0;
    run_window(vt[1]);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (bus.en) begin
        if (r < 3) bus.en = 1'b0;
      end else if (r < 30) begin
        bus.en = 1'b1;
      end
      rst = ($urandom_range(0, 399) == 0);
      bus.temp_in = 18'($urandom);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
